// File: rtl/prog_rom_sync.sv
// Synchronous program memory with registered read and sequential loader.
// Optional PROG_ROM_PIPE_OUT_EN adds a second output register stage.
module prog_rom_sync #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 128,
    parameter logic [DATA_W-1:0] FILL_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              addr_err,
    input  logic              prog_start,
    input  logic              prog_wr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_busy,
    output logic              prog_done,
    output logic [ADDR_W-1:0] prog_count
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_PROG = 1'b1;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_done;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_err;
    logic              w_in_range;
    logic              w_rd;
    logic              w_wr;

    assign w_in_range = {1'b0, address} < DEPTH_EXT;
    assign w_rd       = (r_state == ST_RUN) && rd_en;
    assign w_wr       = (r_state == ST_PROG) && prog_wr;

    // Power-up image: default CPU test program, rest zero
    initial begin
        for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
        r_mem[0] = DATA_W'(8'h86);
        r_mem[1] = DATA_W'(8'h00);
        r_mem[2] = DATA_W'(8'h88);
        r_mem[3] = DATA_W'(8'h01);
        r_mem[4] = DATA_W'(8'h42);
        r_mem[5] = DATA_W'(8'h42);
        r_mem[6] = DATA_W'(8'h26);
        r_mem[7] = DATA_W'(8'h04);
    end

    // Loader write port; contents survive reset
    always @(posedge clk) begin
        if (reset && w_wr) begin
            r_mem[r_cnt[MEM_AW-1:0]] <= prog_data;
        end
    end

    // RUN/PROG sequencing and write pointer
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (prog_start) begin
                        r_state <= ST_PROG;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    if (prog_wr) begin
                        if (r_cnt == LAST_IDX) begin
                            r_state <= ST_RUN;
                            r_cnt   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + ADDR_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // First read stage: lookup or fill value with range flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_rd) begin
            r_valid <= 1'b1;
            if (w_in_range) begin
                r_data <= r_mem[address[MEM_AW-1:0]];
                r_err  <= 1'b0;
            end else begin
                r_data <= FILL_VAL;
                r_err  <= 1'b1;
            end
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end
    end

`ifdef PROG_ROM_PIPE_OUT_EN
    logic [DATA_W-1:0] r_data2;
    logic              r_valid2;
    logic              r_err2;

    // Second output stage delays data and qualifiers together
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data2  <= '0;
            r_valid2 <= 1'b0;
            r_err2   <= 1'b0;
        end else begin
            r_data2  <= r_data;
            r_valid2 <= r_valid;
            r_err2   <= r_err;
        end
    end

    assign data_out = r_data2;
    assign rd_valid = r_valid2;
    assign addr_err = r_err2;
`else
    assign data_out = r_data;
    assign rd_valid = r_valid;
    assign addr_err = r_err;
`endif

    assign prog_busy  = (r_state == ST_PROG);
    assign prog_done  = r_done;
    assign prog_count = r_cnt;

endmodule

// File: tb/tb_prog_rom_sync.sv
// Scoreboard bench for prog_rom_sync: directed reads, programming run,
// reset during programming; latency follows PROG_ROM_PIPE_OUT_EN.
module tb_prog_rom_sync;

`ifdef PROG_ROM_PIPE_OUT_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] address = '0;
    logic       rd_en = 1'b0;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       addr_err;
    logic       prog_start = 1'b0;
    logic       prog_wr = 1'b0;
    logic [7:0] prog_data = '0;
    logic       prog_busy;
    logic       prog_done;
    logic [7:0] prog_count;

    prog_rom_sync dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .rd_valid   (rd_valid),
        .addr_err   (addr_err),
        .prog_start (prog_start),
        .prog_wr    (prog_wr),
        .prog_data  (prog_data),
        .prog_busy  (prog_busy),
        .prog_done  (prog_done),
        .prog_count (prog_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       e;
        int         c;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (prog_done) done_pulses++;

    // Monitor: every result must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].c < cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_read cyc=%0d expected data %h at cyc %0d",
                     cyc, e.d, e.c);
        end
        if (rd_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rd_valid cyc=%0d data=%h err=%b",
                         cyc, data_out, addr_err);
            end else begin
                e = sb.pop_front();
                if (data_out !== e.d || addr_err !== e.e || cyc != e.c) begin
                    errors++;
                    $display("FAIL read cyc=%0d got %h/%b want %h/%b at cyc %0d",
                             cyc, data_out, addr_err, e.d, e.e, e.c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] d, input logic e);
        exp_t x;
        address = a;
        rd_en   = 1'b1;
        x.d = d;
        x.e = e;
        x.c = cyc + LAT;
        sb.push_back(x);
        tick();
    endtask

    task automatic idle(input int n);
        rd_en   = 1'b0;
        prog_wr = 1'b0;
        repeat (n) tick();
    endtask

    logic [7:0] prog0 [0:7] = '{8'h86, 8'h00, 8'h88, 8'h01,
                                8'h42, 8'h42, 8'h26, 8'h04};

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        chk("rst_data_out", data_out, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_prog_busy", prog_busy, 0);
        chk("rst_prog_done", prog_done, 0);
        chk("rst_prog_count", prog_count, 0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) rd(8'(i), prog0[i], 1'b0);
        idle(3);

        rd(8'h80, 8'h00, 1'b1);
        rd(8'h03, 8'h01, 1'b0);
        rd(8'hFF, 8'h00, 1'b1);
        rd(8'h7F, 8'h00, 1'b0);
        rd(8'h06, 8'h26, 1'b0);
        idle(3);
        chk("hold_data_out", data_out, 8'h26);
        chk("idle_addr_err", addr_err, 0);

        // Enter PROG with a read in the same cycle, then reset mid-load
        prog_start = 1'b1;
        rd(8'h02, 8'h88, 1'b0);
        prog_start = 1'b0;
        chk("enter_busy", prog_busy, 1);
        chk("enter_count", prog_count, 0);
        address = 8'h01;
        for (int i = 0; i < 5; i++) begin
            prog_wr    = 1'b1;
            prog_data  = 8'hA0 + 8'(i);
            prog_start = (i == 2);
            tick();
        end
        prog_start = 1'b0;
        rd_en      = 1'b0;
        prog_wr    = 1'b0;
        chk("prog_count_5", prog_count, 5);
        chk("busy_mid", prog_busy, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rstp_busy", prog_busy, 0);
        chk("rstp_count", prog_count, 0);
        chk("rstp_done", prog_done, 0);
        tick();
        chk("rstp_no_done", done_pulses, 0);
        rd(8'h04, 8'hA4, 1'b0);
        rd(8'h05, 8'h42, 1'b0);
        rd(8'h00, 8'hA0, 1'b0);
        idle(3);

        // Full programming run with idle gaps
        prog_start = 1'b1;
        tick();
        prog_start = 1'b0;
        rd_en   = 1'b1;
        address = 8'h00;
        for (int i = 0; i < 128; i++) begin
            if (i == 10 || i == 64) begin
                prog_wr = 1'b0;
                tick();
                chk("gap_count", prog_count, i);
            end
            prog_wr   = 1'b1;
            prog_data = 8'hFF - 8'(i);
            tick();
        end
        prog_wr = 1'b0;
        rd_en   = 1'b0;
        chk("done_pulse", prog_done, 1);
        chk("done_busy", prog_busy, 0);
        chk("done_count", prog_count, 0);
        tick();
        chk("done_once", prog_done, 0);
        chk("done_total", done_pulses, 1);

        rd(8'h00, 8'hFF, 1'b0);
        rd(8'h7F, 8'h80, 1'b0);
        rd(8'h40, 8'hBF, 1'b0);
        rd(8'h0A, 8'hF5, 1'b0);
        rd(8'h80, 8'h00, 1'b1);
        idle(LAT + 3);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
